// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath: sequences fetch,
// decode, execute, memory and writeback, and decodes the ALU operation.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur, nxt, view;
    aluop_t aluop;
    logic   pcwrite, branch;

    function automatic logic [2:0] alu_decode(input aluop_t a, input logic [5:0] f);
        logic [2:0] r;
        r = 3'b010;
        case (a)
            ALUOP_SUB: r = 3'b110;
            ALUOP_FUNCT: begin
                case (f)
                    6'b100010: r = 3'b110;
                    6'b100100: r = 3'b000;
                    6'b100101: r = 3'b001;
                    6'b101010: r = 3'b111;
                    default:   r = 3'b010;
                endcase
            end
            default: r = 3'b010;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:  nxt = memready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYPE:     nxt = EXEC;
                    OP_BEQ:       nxt = BRANCH;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JUMP;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  nxt = memready ? MEMWB : MEMRD;
            MEMWB:  nxt = FETCH;
            MEMWR:  nxt = memready ? FETCH : MEMWR;
            EXEC:   nxt = ALUWB;
            ALUWB:  nxt = FETCH;
            BRANCH: nxt = FETCH;
            ADDIEX: nxt = ADDIWB;
            ADDIWB: nxt = FETCH;
            JUMP:   nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    // While reset is held, outputs present the FETCH decode with all writes suppressed.
    assign view  = reset ? FETCH : cur;
    assign state = view;

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (view)
            FETCH: begin
                irwrite = memready;
                alusrcb = 2'b01;
                pcwrite = memready;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        pcen       = pcwrite | (branch & zero);
        alucontrol = alu_decode(aluop, funct);
        if (reset) begin
            memwrite = 1'b0;
            regwrite = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each driven cycle queues its expected
// state and control word; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memready(memready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .pcen(pcen), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .state(state)
    );

    always #5 clk = ~clk;

    // Control word: {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,pcen}_alusrcb_pcsrc_alucontrol
    localparam logic [14:0] W_FHOLD  = 15'b00000000_01_00_010;
    localparam logic [14:0] W_FACC   = 15'b00100001_01_00_010;
    localparam logic [14:0] W_DEC    = 15'b00000000_11_00_010;
    localparam logic [14:0] W_MEMADR = 15'b00000010_10_00_010;
    localparam logic [14:0] W_MEMRD  = 15'b10000000_00_00_010;
    localparam logic [14:0] W_MEMWB  = 15'b00001100_00_00_010;
    localparam logic [14:0] W_MEMWR  = 15'b11000000_00_00_010;
    localparam logic [14:0] W_EXSLT  = 15'b00000010_00_00_111;
    localparam logic [14:0] W_EXADD  = 15'b00000010_00_00_010;
    localparam logic [14:0] W_EXSUB  = 15'b00000010_00_00_110;
    localparam logic [14:0] W_EXOR   = 15'b00000010_00_00_001;
    localparam logic [14:0] W_EXAND  = 15'b00000010_00_00_000;
    localparam logic [14:0] W_ALUWB  = 15'b00010100_00_00_010;
    localparam logic [14:0] W_BRT    = 15'b00000011_00_01_110;
    localparam logic [14:0] W_BRNT   = 15'b00000010_00_01_110;
    localparam logic [14:0] W_ADDIWB = 15'b00000100_00_00_010;
    localparam logic [14:0] W_JUMP   = 15'b00000001_00_10_010;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, ILL = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] ctl;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pushed = 0;
    int   popped = 0;

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic mr,
                        input logic [3:0] es, input logic [14:0] ec);
        exp_t e;
        reset = r; op = o; funct = f; zero = z; memready = mr;
        e.st = es; e.ctl = ec; e.idx = pushed;
        q.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [14:0] got;
            e = q.pop_front();
            popped++;
            got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen,
                   alusrcb, pcsrc, alucontrol};
            tests++;
            if (state !== e.st) begin
                fails++;
                $display("FAIL step%0d state: got %0d expected %0d", e.idx, state, e.st);
            end
            tests++;
            if (got !== e.ctl) begin
                fails++;
                $display("FAIL step%0d ctl: got %b expected %b", e.idx, got, e.ctl);
            end
        end
    end

    initial begin
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b0;
        @(posedge clk);
        #1;
        // Reset: FETCH decode with writes suppressed even though memready=1
        step(1, LW, 6'd0, 0, 1, 4'd0, W_FHOLD);
        step(1, LW, 6'd0, 0, 1, 4'd0, W_FHOLD);
        // lw, memready=1 throughout: 0,1,2,3,4
        step(0, LW, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, LW, 6'd0, 0, 1, 4'd1, W_DEC);
        step(0, LW, 6'd0, 0, 1, 4'd2, W_MEMADR);
        step(0, LW, 6'd0, 0, 1, 4'd3, W_MEMRD);
        step(0, LW, 6'd0, 0, 1, 4'd4, W_MEMWB);
        // sw with three held MEMWR cycles: memwrite for 4 cycles
        step(0, SW, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, SW, 6'd0, 0, 0, 4'd1, W_DEC);
        step(0, SW, 6'd0, 0, 0, 4'd2, W_MEMADR);
        step(0, SW, 6'd0, 0, 0, 4'd5, W_MEMWR);
        step(0, SW, 6'd0, 0, 0, 4'd5, W_MEMWR);
        step(0, SW, 6'd0, 0, 0, 4'd5, W_MEMWR);
        step(0, SW, 6'd0, 0, 1, 4'd5, W_MEMWR);
        // R-type slt
        step(0, RT, 6'b101010, 0, 1, 4'd0, W_FACC);
        step(0, RT, 6'b101010, 0, 1, 4'd1, W_DEC);
        step(0, RT, 6'b101010, 0, 1, 4'd6, W_EXSLT);
        step(0, RT, 6'b101010, 0, 1, 4'd7, W_ALUWB);
        // R-type sub
        step(0, RT, 6'b100010, 0, 1, 4'd0, W_FACC);
        step(0, RT, 6'b100010, 0, 1, 4'd1, W_DEC);
        step(0, RT, 6'b100010, 0, 1, 4'd6, W_EXSUB);
        step(0, RT, 6'b100010, 0, 1, 4'd7, W_ALUWB);
        // R-type or, then and, then an unknown funct falls back to add
        step(0, RT, 6'b100101, 0, 1, 4'd0, W_FACC);
        step(0, RT, 6'b100101, 0, 1, 4'd1, W_DEC);
        step(0, RT, 6'b100101, 0, 1, 4'd6, W_EXOR);
        step(0, RT, 6'b100101, 0, 1, 4'd7, W_ALUWB);
        step(0, RT, 6'b100100, 0, 1, 4'd0, W_FACC);
        step(0, RT, 6'b100100, 0, 1, 4'd1, W_DEC);
        step(0, RT, 6'b100100, 0, 1, 4'd6, W_EXAND);
        step(0, RT, 6'b100100, 0, 1, 4'd7, W_ALUWB);
        step(0, RT, 6'b000111, 0, 1, 4'd0, W_FACC);
        step(0, RT, 6'b000111, 0, 1, 4'd1, W_DEC);
        step(0, RT, 6'b000111, 0, 1, 4'd6, W_EXADD);
        step(0, RT, 6'b000111, 0, 1, 4'd7, W_ALUWB);
        // beq taken (zero=1 also in DECODE must not raise pcen) and not taken
        step(0, BEQ, 6'd0, 1, 1, 4'd0, W_FACC);
        step(0, BEQ, 6'd0, 1, 1, 4'd1, W_DEC);
        step(0, BEQ, 6'd0, 1, 1, 4'd8, W_BRT);
        step(0, BEQ, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, BEQ, 6'd0, 0, 1, 4'd1, W_DEC);
        step(0, BEQ, 6'd0, 0, 1, 4'd8, W_BRNT);
        // FETCH held two cycles, then addi
        step(0, ADDI, 6'd0, 0, 0, 4'd0, W_FHOLD);
        step(0, ADDI, 6'd0, 0, 0, 4'd0, W_FHOLD);
        step(0, ADDI, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, ADDI, 6'd0, 0, 0, 4'd1, W_DEC);
        step(0, ADDI, 6'd0, 0, 0, 4'd9, W_MEMADR);
        step(0, ADDI, 6'd0, 0, 0, 4'd10, W_ADDIWB);
        // j, memready low outside FETCH is ignored
        step(0, J, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, J, 6'd0, 0, 0, 4'd1, W_DEC);
        step(0, J, 6'd0, 0, 0, 4'd11, W_JUMP);
        // reset in the middle of a MEMRD hold: no writeback ever
        step(0, LW, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, LW, 6'd0, 0, 1, 4'd1, W_DEC);
        step(0, LW, 6'd0, 0, 0, 4'd2, W_MEMADR);
        step(0, LW, 6'd0, 0, 0, 4'd3, W_MEMRD);
        step(0, LW, 6'd0, 0, 0, 4'd3, W_MEMRD);
        step(1, LW, 6'd0, 0, 1, 4'd0, W_FHOLD);
        step(0, LW, 6'd0, 0, 0, 4'd0, W_FHOLD);
        // reset in the middle of a MEMWR hold
        step(0, SW, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, SW, 6'd0, 0, 1, 4'd1, W_DEC);
        step(0, SW, 6'd0, 0, 0, 4'd2, W_MEMADR);
        step(0, SW, 6'd0, 0, 0, 4'd5, W_MEMWR);
        step(1, SW, 6'd0, 0, 0, 4'd0, W_FHOLD);
        step(0, SW, 6'd0, 0, 0, 4'd0, W_FHOLD);
        // illegal op returns to FETCH straight from DECODE
        step(0, ILL, 6'd0, 0, 1, 4'd0, W_FACC);
        step(0, ILL, 6'd0, 0, 1, 4'd1, W_DEC);
        step(0, ILL, 6'd0, 0, 0, 4'd0, W_FHOLD);
        // every queued expectation must have been consumed by the monitor
        repeat (2) @(posedge clk);
        tests++;
        if (popped != pushed || q.size() != 0) begin
            fails++;
            $display("FAIL drain: checked %0d of %0d expected entries", popped, pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: op  input  6  instr[31:26] from instruction register.
REQ-004 SHALL have port: funct  input  6  instr[5:0] from instruction register.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have port: memready  input  1  memory access complete this cycle.
REQ-007 SHALL have outputs, each 1 bit: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen.
REQ-008 SHALL have output: alusrcb  2 bits  00=B, 01=4, 10=signimm, 11=signimm<<2.
REQ-009 SHALL have output: pcsrc  2 bits  00=ALU result, 01=ALUOut, 10=jump target.
REQ-010 SHALL have output: alucontrol  3 bits  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 SHALL have output: state  4 bits  current state encoding, for debug.

Function
REQ-012 SHALL be a Moore FSM with states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-013 FETCH: iord=0, irwrite=memready, alusrca=0, alusrcb=01, aluop=add, pcsrc=00, pcwrite=memready. Stay while memready=0; go to DECODE when memready=1.
REQ-014 DECODE: alusrca=0, alusrcb=11, aluop=add. Next state by op:
 - 100011 (lw) or 101011 (sw) -> MEMADR
 - 000000 (R-type) -> EXEC
 - 000100 (beq) -> BRANCH
 - 001000 (addi) -> ADDIEX
 - 000010 (j) -> JUMP
 - any other op -> FETCH
REQ-015 MEMADR: alusrca=1, alusrcb=10, aluop=add. Next MEMRD if op=lw, else MEMWR.
REQ-016 MEMRD: iord=1. Hold until memready=1, then MEMWB.
REQ-017 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-018 MEMWR: iord=1, memwrite=1. Hold while memready=0. memwrite stays asserted every held cycle. Next FETCH on memready=1.
REQ-019 EXEC: alusrca=1, alusrcb=00, aluop=funct; next ALUWB.
REQ-020 ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-021 BRANCH: alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=1; next FETCH.
REQ-022 ADDIEX: alusrca=1, alusrcb=10, aluop=add; next ADDIWB.
REQ-023 ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-024 JUMP: pcsrc=10, pcwrite=1; next FETCH.
REQ-025 Every control not listed for a state SHALL be 0 in that state; alucontrol SHALL be 010 when unused.
REQ-026 pcen SHALL equal pcwrite OR (branch AND zero), computed combinationally in the same cycle.
REQ-027 alucontrol SHALL decode as: aluop=add -> 010; aluop=sub -> 110. aluop=funct maps funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
REQ-028 Latencies in cycles, with memready=1 at first opportunity: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-029 memready SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=FETCH on that edge, from any state, including mid-hold in MEMRD or MEMWR.
REQ-031 While reset=1, memwrite, regwrite, irwrite and pcen SHALL be forced to 0 combinationally. All other outputs SHALL take their FETCH values.
REQ-032 The first fetch SHALL begin in the cycle after reset deasserts.

Verification
REQ-033 Reset, then op=100011 with memready=1 throughout -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4.
REQ-034 op=101011 with memready=0 for 3 cycles in MEMWR -> memwrite=1 for exactly 4 cycles, then state=0.
REQ-035 op=000000, funct=101010 -> alucontrol=111 in EXEC. regwrite=1 and regdst=1 in ALUWB. Total 4 cycles.
REQ-036 op=000100, zero=1 in BRANCH -> pcen=1, pcsrc=01. With zero=0 -> pcen=0. Both return to FETCH.
REQ-037 FETCH with memready=0 for 2 cycles -> irwrite=0 and pcen=0 while held. irwrite=1 and pcen=1 in the accept cycle.
REQ-038 Assert reset during MEMRD hold -> state=0 next cycle and regwrite never asserts. Illegal op=111111 -> DECODE returns to FETCH.
